// File: rtl/bj_predict_resolve_pkg.sv
// Shared encodings and helpers for the EX-stage branch resolver
// and its bimodal history table.
package bj_predict_resolve_pkg;

  localparam logic [2:0] BJ_BEQ  = 3'b000;
  localparam logic [2:0] BJ_BNE  = 3'b001;
  localparam logic [2:0] BJ_NONE = 3'b010;
  localparam logic [2:0] BJ_JUMP = 3'b011;
  localparam logic [2:0] BJ_BLT  = 3'b100;
  localparam logic [2:0] BJ_BGE  = 3'b101;
  localparam logic [2:0] BJ_BLTU = 3'b110;
  localparam logic [2:0] BJ_BGEU = 3'b111;

  localparam logic [1:0] CNT_WNT = 2'b01;

  function automatic int unsigned bht_idx(
    input logic [63:0] pc,
    input int unsigned entries
  );
    return 32'((pc >> 2) & 64'(entries - 1));
  endfunction

endpackage

// File: rtl/bj_predict_resolve_if.sv
// Fetch lookup and EX resolve signals between the pipeline
// and the branch resolver.
interface bj_predict_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  IF_PC;
  logic             IF_PRED_TAKEN;
  logic             EX_VALID;
  logic [2:0]       EX_BRANCH_JUMP;
  logic [XLEN-1:0]  EX_DATA1;
  logic [XLEN-1:0]  EX_DATA2;
  logic [XLEN-1:0]  EX_PC;
  logic [XLEN-1:0]  EX_TARGET;
  logic             EX_PRED_TAKEN;
  logic             FLUSH;
  logic [XLEN-1:0]  REDIRECT_PC;
  logic             PC_SEL_OUT;
  logic [CNT_W-1:0] BRANCH_CNT;
  logic [CNT_W-1:0] MISPRED_CNT;

  modport master (
    output IF_PC, EX_VALID, EX_BRANCH_JUMP,
    output EX_DATA1, EX_DATA2, EX_PC,
    output EX_TARGET, EX_PRED_TAKEN,
    input  IF_PRED_TAKEN, FLUSH, REDIRECT_PC,
    input  PC_SEL_OUT, BRANCH_CNT, MISPRED_CNT
  );

  modport slave (
    input  IF_PC, EX_VALID, EX_BRANCH_JUMP,
    input  EX_DATA1, EX_DATA2, EX_PC,
    input  EX_TARGET, EX_PRED_TAKEN,
    output IF_PRED_TAKEN, FLUSH, REDIRECT_PC,
    output PC_SEL_OUT, BRANCH_CNT, MISPRED_CNT
  );
endinterface

// File: rtl/bj_bht.sv
// Bimodal table of 2-bit saturating counters: one async read
// port for fetch, one saturating update port from EX.
module bj_bht
  import bj_predict_resolve_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_taken,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  logic [1:0] ctr [ENTRIES];

  // No bypass: a same-index read sees the pre-update value.
  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr[i] <= CNT_WNT;
    end else if (wr_en) begin
      if (wr_taken && ctr[wr_idx] != 2'b11)
        ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
      else if (!wr_taken && ctr[wr_idx] != 2'b00)
        ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/bj_predict_resolve.sv
// EX-stage branch/jump resolver with bimodal prediction,
// registered flush/redirect and saturating statistics.
module bj_predict_resolve
  import bj_predict_resolve_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input logic CLK,
  input logic RESET_N,
  bj_predict_resolve_if.slave bus
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic [IW-1:0]   idx_if;
  logic [IW-1:0]   idx_ex;
  logic            acc;
  logic            cond;
  logic            taken;
  logic            mis;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            pc_sel;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  assign idx_if = IW'(bht_idx(64'(bus.IF_PC), BHT_ENTRIES));
  assign idx_ex = IW'(bht_idx(64'(bus.EX_PC), BHT_ENTRIES));

  assign eq   = bus.EX_DATA1 == bus.EX_DATA2;
  assign lt_s = $signed(bus.EX_DATA1) < $signed(bus.EX_DATA2);
  assign lt_u = bus.EX_DATA1 < bus.EX_DATA2;

  always_comb begin
    taken = 1'b0;
    unique case (bus.EX_BRANCH_JUMP)
      BJ_BEQ:  taken = eq;
      BJ_BNE:  taken = !eq;
      BJ_NONE: taken = 1'b0;
      BJ_JUMP: taken = 1'b1;
      BJ_BLT:  taken = lt_s;
      BJ_BGE:  taken = !lt_s;
      BJ_BLTU: taken = lt_u;
      BJ_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  // The slot behind a flush is wrong-path and ignored entirely.
  assign acc  = bus.EX_VALID && !flush;
  assign cond = bus.EX_BRANCH_JUMP != BJ_NONE
             && bus.EX_BRANCH_JUMP != BJ_JUMP;
  assign mis  = acc && bus.EX_BRANCH_JUMP != BJ_NONE
             && taken != bus.EX_PRED_TAKEN;

  bj_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .rd_idx   (idx_if),
    .rd_taken (bus.IF_PRED_TAKEN),
    .wr_en    (acc && cond),
    .wr_idx   (idx_ex),
    .wr_taken (taken)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      pc_sel      <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      flush <= mis;
      if (acc) begin
        pc_sel      <= taken;
        redirect_pc <= taken ? bus.EX_TARGET
                             : bus.EX_PC + XLEN'(4);
      end
      if (acc && bus.EX_BRANCH_JUMP != BJ_NONE
          && branch_cnt != '1)
        branch_cnt <= branch_cnt + 1'b1;
      if (mis && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign bus.FLUSH       = flush;
  assign bus.REDIRECT_PC = redirect_pc;
  assign bus.PC_SEL_OUT  = pc_sel;
  assign bus.BRANCH_CNT  = branch_cnt;
  assign bus.MISPRED_CNT = mispred_cnt;

endmodule

// File: doc/bj_predict_resolve.md
Name: bj_predict_resolve

Overview:
- Parametrised successor to the execute-stage branch/jump detector.
- Resolves conditional branches and jumps in EX, and keeps a bimodal branch history table (BHT) of 2-bit saturating counters that fetch reads for a taken/not-taken prediction.
- Compares the resolved outcome with the prediction carried down the pipe and emits a registered flush/redirect.
- Keeps saturating branch and mispredict counters for performance debug.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of BHT counters; must be a power of two, >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- IF_PC  input  XLEN  fetch PC used for BHT lookup.
- IF_PRED_TAKEN  output  1  combinational: MSB of BHT[IF_PC index].
- EX_VALID  input  1  EX holds a valid instruction.
- EX_BRANCH_JUMP  input  3  000 BEQ, 001 BNE, 010 none, 011 JAL/JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- EX_DATA1, EX_DATA2  input  XLEN  compare operands (rs1, rs2).
- EX_PC  input  XLEN  PC of the EX instruction.
- EX_TARGET  input  XLEN  computed branch/jump target.
- EX_PRED_TAKEN  input  1  prediction made at fetch for this instruction.
- FLUSH  output  1  registered; squash younger instructions.
- REDIRECT_PC  output  XLEN  registered; fetch restart address, valid while FLUSH=1.
- PC_SEL_OUT  output  1  registered resolved taken flag of the last accepted instruction.
- BRANCH_CNT, MISPRED_CNT  output  CNT_W  saturating statistics counters.

Behaviour:
- Reset (async, RESET_N=0): every BHT entry = 2'b01 (weakly not-taken); FLUSH=0, REDIRECT_PC=0, PC_SEL_OUT=0, both counters=0. Release is synchronous to CLK.
- Index: idx = PC[2 +: log2(BHT_ENTRIES)]; PC bits [1:0] are ignored.
- Accept condition: acc = EX_VALID && !FLUSH. While FLUSH is high, the EX slot is wrong-path and is ignored completely (shadow squash).
- Taken evaluation:
  - BEQ: eq. BNE: !eq.
  - BLT / BGE: signed lt / !lt.
  - BLTU / BGEU: unsigned lt / !lt.
  - 011: always taken. 010: never taken.
- Mispredict rule: mis = acc && type != 010 && (taken != EX_PRED_TAKEN).
- Next edge after acc:
  - PC_SEL_OUT <= taken.
  - FLUSH <= mis.
  - REDIRECT_PC <= taken ? EX_TARGET : EX_PC+4 (modulo 2^XLEN); otherwise holds its old value.
  - Latency: one cycle from EX to FLUSH.
- No acc: FLUSH <= 0; PC_SEL_OUT and REDIRECT_PC hold.
- FLUSH is a single-cycle pulse; back-to-back mispredicts cannot occur because the slot after FLUSH is squashed.
- BHT update (acc, conditional types only, i.e. not 010/011):
  - taken: counter +1, saturating at 11.
  - not taken: counter -1, saturating at 00.
  - Jumps and non-branches never touch the BHT.
- Read/write collision: IF_PC index equal to EX_PC index in the same cycle returns the pre-update value; there is no bypass.
- Statistics:
  - BRANCH_CNT += 1 on acc with type != 010.
  - MISPRED_CNT += 1 on mis.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-operation clears everything immediately, including a pending FLUSH.

Decomposition:
- Shared package holds:
  - BRANCH_JUMP encoding constants (BJ_BEQ..BJ_BGEU, BJ_NONE, BJ_JUMP).
  - 2-bit counter reset value (CNT_WNT = 2'b01).
  - Index-function helper.
- One natural sub-module: bj_bht, the counter array with async reset, a combinational read port and a saturating update write port.
- Compare, mispredict and statistics logic stay in the top module.

Test Plan:
- Reset, then IF_PC=0x100 -> IF_PRED_TAKEN=0; all outputs 0; counters 0.
- BEQ, DATA1=DATA2=5, PC=0x100, TARGET=0x140, pred=0 -> next cycle FLUSH=1, REDIRECT_PC=0x140, PC_SEL_OUT=1, MISPRED_CNT=1; BHT[0x100 idx]=10, so IF_PRED_TAKEN=1.
- BLT vs BLTU with DATA1=0xFFFFFFFF, DATA2=1: BLT taken, BLTU not taken. With pred=1 on the BLTU -> FLUSH=1, REDIRECT_PC=EX_PC+4.
- FLUSH-shadow: mispredict, then EX_VALID=1 mispredicting in the next cycle -> second slot ignored: FLUSH drops to 0, counters and BHT unchanged.
- Saturation: four taken BGE at the same PC -> counter 11 and stays; JAL with pred=0 -> FLUSH, BHT untouched. Force CNT_W=4 and run 20 branches -> BRANCH_CNT=15.
- Collision: IF_PC idx == EX_PC idx while updating 01->10 -> IF_PRED_TAKEN=0 this cycle, 1 next cycle. Assert RESET_N while FLUSH=1 -> FLUSH=0 immediately.
